// File: rtl/router_1xn_core.sv
// router_1xn_core: 1-to-N byte-serial packet router with per-channel
// first-word-fall-through FIFOs, parity check and stalled-reader flush.
module router_1xn_core #(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pkt_vld,
  input  logic [DATA_W-1:0]        din,
  output logic                     busy,
  output logic                     err,
  input  logic [NUM_CH-1:0]        re,
  output logic [NUM_CH-1:0]        vld_out,
  output logic [NUM_CH*DATA_W-1:0] d_out
);
  localparam int AW = $clog2(NUM_CH);
  localparam int LW = DATA_W - AW;
  localparam int NX = 1 << AW;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   NCH   = (AW+1)'(NUM_CH);
  localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] SLAST = SW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, DATA, PAR, CHK, DROP
  } state_t;

  state_t state, state_n;

  logic [AW-1:0]     addr, din_addr, wr_ch;
  logic [LW-1:0]     len, cnt, din_len;
  logic [DATA_W-1:0] hdr, par, wr_data;
  logic              din_bad, wr, err_set, acc;
  logic [NUM_CH-1:0] full;
  logic [NX-1:0]     full_x;

  assign din_addr = din[AW-1:0];
  assign din_len  = din[DATA_W-1:AW];
  assign din_bad  = {1'b0, din_addr} >= NCH;
  assign acc      = pkt_vld && !busy;

  always_comb begin
    full_x = '0;
    full_x[NUM_CH-1:0] = full;
  end

  // HDR keeps busy high through the cycle that writes the held header,
  // so the header and the next source byte never compete for the FIFO.
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    wr      = 1'b0;
    wr_ch   = addr;
    wr_data = din;
    err_set = 1'b0;
    unique case (state)
      IDLE: begin
        wr_ch = din_addr;
        if (pkt_vld) begin
          if (din_bad) begin
            state_n = DROP;
            err_set = 1'b1;
          end else if (full_x[din_addr]) begin
            state_n = HDR;
          end else begin
            wr      = 1'b1;
            state_n = (din_len == '0) ? PAR : DATA;
          end
        end
      end
      HDR: begin
        busy    = 1'b1;
        wr_data = hdr;
        if (!pkt_vld) begin
          state_n = IDLE;
          err_set = 1'b1;
        end else if (!full_x[addr]) begin
          wr      = 1'b1;
          state_n = (len == '0) ? PAR : DATA;
        end
      end
      DATA: begin
        busy = full_x[addr];
        if (!pkt_vld) begin
          state_n = IDLE;
          err_set = 1'b1;
        end else if (!full_x[addr]) begin
          wr = 1'b1;
          if (cnt == len - LW'(1)) state_n = PAR;
        end
      end
      PAR: begin
        busy = full_x[addr];
        if (!pkt_vld) begin
          state_n = IDLE;
          err_set = 1'b1;
        end else if (!full_x[addr]) begin
          wr      = 1'b1;
          err_set = (din != par);
          state_n = CHK;
        end
      end
      CHK: begin
        busy    = 1'b1;
        state_n = IDLE;
      end
      DROP: begin
        if (pkt_vld && cnt == len) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      addr  <= '0;
      len   <= '0;
      cnt   <= '0;
      hdr   <= '0;
      par   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      err   <= err_set;
      if (acc) begin
        if (state == IDLE) begin
          addr <= din_addr;
          len  <= din_len;
          hdr  <= din;
          par  <= din;
          cnt  <= '0;
        end else begin
          cnt <= cnt + LW'(1);
          if (state == DATA) par <= par ^ din;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     rp, wp;
    logic [CW-1:0]     n;
    logic [SW-1:0]     stall;
    logic              push, pop, flush;

    assign push       = wr && (wr_ch == AW'(k));
    assign pop        = re[k] && vld_out[k];
    assign flush      = vld_out[k] && !re[k] && (stall == SLAST);
    assign vld_out[k] = (n != '0);
    assign full[k]    = (n == FULL);
    assign d_out[k*DATA_W +: DATA_W] = vld_out[k] ? mem[rp] : '0;

    // A flush discards everything, including a byte pushed this cycle.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rp    <= '0;
        wp    <= '0;
        n     <= '0;
        stall <= '0;
      end else if (flush) begin
        rp    <= '0;
        wp    <= '0;
        n     <= '0;
        stall <= '0;
      end else begin
        if (push) wp <= wp + PW'(1);
        if (pop)  rp <= rp + PW'(1);
        n     <= n + CW'(push) - CW'(pop);
        stall <= (re[k] || !vld_out[k]) ? '0 : stall + SW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push && !flush) mem[wp] <= wr_data;
    end
  end

endmodule
